// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - CPU load/store to word-aligned valid/ready bus bridge
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        req_valid_q, req_valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic        access;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] load_w;
    logic [31:0] load_ext;

    assign access = MemRead | MemWrite;
    assign stall  = access & (state_q != DONE);

    always_comb begin
        be_new     = 4'b1111;
        wdata_new  = wdata;
        misaligned = 1'b0;
        case (MemSize)
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new     = 4'b0011 << addr[1:0];
                wdata_new  = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    // Shift the addressed lane down to bit 0 before extending.
    always_comb begin
        load_w = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & load_w[7]}}, load_w[7:0]};
            2'b01:   load_ext = {{16{sign_q & load_w[15]}}, load_w[15:0]};
            default: load_ext = load_w;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
        rdata_d     = '0;
        fault_d     = 1'b0;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if ((MemRead & MemWrite) | misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        size_d      = MemSize;
                        sign_d      = MemSign;
                        off_d       = addr[1:0];
                        we_d        = MemWrite;
                        addr_d      = {addr[31:2], 2'b00};
                        wdata_d     = wdata_new;
                        be_d        = be_new;
                        req_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                // The budget wins over a handshake landing on its final cycle.
                if (cnt_q == TMAX) begin
                    state_d     = DONE;
                    fault_d     = 1'b1;
                    req_valid_d = 1'b0;
                end else if (bus_req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_rsp_valid) begin
                    state_d = DONE;
                    rdata_d = we_q ? 32'd0 : load_ext;
                end else if (cnt_q == TMAX) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            off_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    assign rdata         = rdata_q;
    assign fault         = fault_q;
    assign bus_req_valid = req_valid_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_be        = be_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb/tb_lsu_bus_bridge.sv - scoreboard bench for lsu_bus_bridge
module tb_lsu_bus_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, MemSign;
    logic [1:0]  MemSize;
    logic [31:0] addr, wdata, rdata;
    logic        stall, fault;
    logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    lsu_bus_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSign(MemSign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic [7:0]  stalls;
        logic        aborted;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    int n_checks = 0;
    int n_fail   = 0;

    int          ready_delay = 0;
    int          rsp_delay   = 0;
    bit          never_ready = 1'b0;
    logic [31:0] rsp_data    = '0;
    int          rcnt = 0;
    int          pcnt = 0;
    bit          pend = 1'b0;
    int          stall_cnt = 0;

    // Bus slave model: acts 1 time unit after each falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            pend = 1'b0;
            rcnt = 0;
        end else begin
            bus_rsp_valid = 1'b0;
            if (pend) begin
                if (pcnt >= rsp_delay) begin
                    bus_rsp_valid = 1'b1;
                    bus_rdata     = rsp_data;
                    pend          = 1'b0;
                end else begin
                    pcnt++;
                end
            end
            if (bus_req_valid && !never_ready && rcnt >= ready_delay) begin
                bus_req_ready = 1'b1;
                pend = 1'b1;
                pcnt = 0;
                rcnt = 0;
            end else begin
                bus_req_ready = 1'b0;
                if (bus_req_valid) rcnt++;
                else rcnt = 0;
            end
        end
    end

    // Monitor: samples just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            stall_cnt = 0;
        end else begin
            if (bus_req_valid) begin
                n_checks++;
                if (exp_bus.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_req unexpected: addr=%h be=%b", bus_addr, bus_be);
                end else begin
                    if ({bus_we, bus_addr, bus_wdata, bus_be} !== exp_bus[0]) begin
                        n_fail++;
                        $display("FAIL bus_fields: got we=%b addr=%h wdata=%h be=%b want we=%b addr=%h wdata=%h be=%b",
                                 bus_we, bus_addr, bus_wdata, bus_be,
                                 exp_bus[0].we, exp_bus[0].addr, exp_bus[0].wdata, exp_bus[0].be);
                    end
                    if (bus_req_ready) void'(exp_bus.pop_front());
                end
            end
            if (MemRead | MemWrite) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    n_checks++;
                    if (exp_rsp.size() == 0) begin
                        n_fail++;
                        $display("FAIL done unexpected: rdata=%h fault=%b", rdata, fault);
                    end else begin
                        rsp_t e;
                        e = exp_rsp.pop_front();
                        if (rdata !== e.rdata) begin
                            n_fail++;
                            $display("FAIL rdata: got %h want %h", rdata, e.rdata);
                        end
                        n_checks++;
                        if (fault !== e.fault) begin
                            n_fail++;
                            $display("FAIL fault: got %b want %b", fault, e.fault);
                        end
                        n_checks++;
                        if (stall_cnt != int'(e.stalls)) begin
                            n_fail++;
                            $display("FAIL stall_cycles: got %0d want %0d", stall_cnt, e.stalls);
                        end
                        n_checks++;
                        if (bus_req_valid !== 1'b0) begin
                            n_fail++;
                            $display("FAIL req_valid_in_done: got %b want 0", bus_req_valid);
                        end
                        if (e.aborted && exp_bus.size() != 0) void'(exp_bus.pop_front());
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSign = 1'b0;
        addr = '0; wdata = '0;
    endtask

    // Called at falling edge + 2; returns at falling edge + 2 of the cycle after DONE.
    task automatic do_acc(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bus_rd,
                          input int rdy_dly, input int rsp_dly, input bit has_bus,
                          input logic [31:0] exp_wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd, input bit exp_f, input int exp_st);
        bit done;
        ready_delay = rdy_dly;
        rsp_delay   = rsp_dly;
        rsp_data    = bus_rd;
        if (has_bus) exp_bus.push_back({wr, {a[31:2], 2'b00}, exp_wd, exp_be});
        exp_rsp.push_back({exp_rd, exp_f, 8'(exp_st), never_ready});
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSign = sg; addr = a; wdata = wd;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: addr=%h no DONE within 100 cycles", a);
            exp_bus.delete();
            exp_rsp.delete();
        end
        @(negedge clk); #2;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
        #12;
        check("reset_rdata", rdata, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        check("reset_req_valid", {31'd0, bus_req_valid}, 32'd0);
        check("reset_bus_addr", bus_addr, 32'd0);
        check("reset_bus_be", {28'd0, bus_be}, 32'd0);
        check("reset_stall_idle", {31'd0, stall}, 32'd0);
        @(negedge clk); #2; rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("idle_no_request", {31'd0, bus_req_valid}, 32'd0);

        // loads
        do_acc(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 3);
        do_acc(1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF0000, 0, 0, 1, 32'h0, 4'b1000, 32'hFFFFFF80, 0, 3);
        do_acc(1, 0, 2'b00, 0, 32'h103, 0, 32'h80FF0000, 0, 0, 1, 32'h0, 4'b1000, 32'h00000080, 0, 3);
        do_acc(1, 0, 2'b01, 0, 32'h102, 0, 32'h80FF0000, 0, 0, 1, 32'h0, 4'b1100, 32'h000080FF, 0, 3);
        do_acc(1, 0, 2'b01, 1, 32'h102, 0, 32'h80FF0000, 0, 0, 1, 32'h0, 4'b1100, 32'hFFFF80FF, 0, 3);
        do_acc(1, 0, 2'b00, 1, 32'h101, 0, 32'h0000AB00, 0, 0, 1, 32'h0, 4'b0010, 32'hFFFFFFAB, 0, 3);
        do_acc(1, 0, 2'b11, 0, 32'h108, 0, 32'h01234567, 0, 0, 1, 32'h0, 4'b1111, 32'h01234567, 0, 3);
        // stores, with delayed ready / response
        do_acc(0, 1, 2'b00, 0, 32'h201, 32'h12345678, 32'hFFFFFFFF, 5, 0, 1, 32'h78787878, 4'b0010, 32'h0, 0, 8);
        do_acc(0, 1, 2'b01, 0, 32'h202, 32'hAABBCCDD, 32'hFFFFFFFF, 0, 2, 1, 32'hCCDDCCDD, 4'b1100, 32'h0, 0, 5);
        do_acc(0, 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 1, 1, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 5);
        // faults without bus activity
        do_acc(1, 0, 2'b10, 0, 32'h102, 0, 32'h11111111, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 1);
        do_acc(1, 0, 2'b01, 1, 32'h101, 0, 32'h11111111, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 1);
        do_acc(1, 1, 2'b10, 0, 32'h100, 0, 32'h11111111, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 1);
        do_acc(1, 0, 2'b11, 0, 32'h10A, 0, 32'h11111111, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 1);
        // timeout: ready never comes, request held TO cycles then dropped
        never_ready = 1'b1;
        do_acc(1, 0, 2'b10, 0, 32'h400, 0, 32'h22222222, 0, 0, 1, 32'h0, 4'b1111, 32'h0, 1, 1 + TO);
        never_ready = 1'b0;
        do_acc(1, 0, 2'b10, 0, 32'h104, 0, 32'h5A5AA5A5, 0, 0, 1, 32'h0, 4'b1111, 32'h5A5AA5A5, 0, 3);

        // reset while waiting for the response
        rsp_delay = 10; ready_delay = 0; rsp_data = 32'h33333333;
        exp_bus.push_back({1'b0, 32'h300, 32'h0, 4'b1111});
        MemRead = 1'b1; MemSize = 2'b10; addr = 32'h300;
        @(negedge clk); #2;
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_req_valid", {31'd0, bus_req_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_bus_be", {28'd0, bus_be}, 32'd0);
        check("rst_stall_comb", {31'd0, stall}, 32'd1);
        idle_inputs();
        @(negedge clk); #2; rst = 1'b1;
        @(negedge clk); #2;
        bus_rdata = 32'h12345678; bus_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check("post_rst_rdata", rdata, 32'd0);
            check("post_rst_fault", {31'd0, fault}, 32'd0);
            check("post_rst_req_valid", {31'd0, bus_req_valid}, 32'd0);
        end
        do_acc(1, 0, 2'b01, 0, 32'h106, 0, 32'hBEEF0000, 0, 0, 1, 32'h0, 4'b1100, 32'h0000BEEF, 0, 3);

        repeat (3) @(negedge clk);
        #5;
        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
